// File: rtl/dmem_arbiter_if.sv
// Request/response and RAM-side signal bundle for the shared data-memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              i_req0_valid;
  logic              i_req0_we;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [31:0]       i_req0_wdata;
  logic [3:0]        i_req0_be;
  logic              o_req0_ready;
  logic              o_rsp0_valid;
  logic [31:0]       o_rsp0_rdata;

  logic              i_req1_valid;
  logic              i_req1_we;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [31:0]       i_req1_wdata;
  logic [3:0]        i_req1_be;
  logic              o_req1_ready;
  logic              o_rsp1_valid;
  logic [31:0]       o_rsp1_rdata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [3:0]        o_mem_be;
  logic              o_mem_wren;
  logic [31:0]       i_mem_rdata;

  modport slave (
    input  i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata, i_req0_be,
    output o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    input  i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_be,
    output o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_be, o_mem_wren,
    input  i_mem_rdata
  );

  modport master (
    output i_req0_valid, i_req0_we, i_req0_addr, i_req0_wdata, i_req0_be,
    input  o_req0_ready, o_rsp0_valid, o_rsp0_rdata,
    output i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_be,
    input  o_req1_ready, o_rsp1_valid, o_rsp1_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_be, o_mem_wren,
    output i_mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for a single-port synchronous data RAM.
// Read data is steered back to the issuing port by a MEM_LAT-deep tag pipeline.
module dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  dmem_arbiter_if.slave  bus
);

  logic               ptr_q;
  logic               ptr_d;
  logic               gnt0_s;
  logic               gnt1_s;
  logic               push_vld_s;
  logic               out_vld_s;
  logic [MEM_LAT-1:0] tag_vld_q;
  logic [MEM_LAT-1:0] tag_vld_d;
  logic [MEM_LAT-1:0] tag_port_q;
  logic [MEM_LAT-1:0] tag_port_d;

  // Grant selection: the pointer holds the last winner, so contention goes to the other port
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (i_rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.i_req0_valid && bus.i_req1_valid) begin
      gnt0_s = ptr_q;
      gnt1_s = ~ptr_q;
    end else begin
      gnt0_s = bus.i_req0_valid;
      gnt1_s = bus.i_req1_valid;
    end
  end

  // RAM port drive and next pointer / tag state
  always_comb begin
    bus.o_req0_ready = gnt0_s;
    bus.o_req1_ready = gnt1_s;
    bus.o_mem_addr   = '0;
    bus.o_mem_wdata  = 32'h0000_0000;
    bus.o_mem_be     = 4'h0;
    bus.o_mem_wren   = 1'b0;
    push_vld_s       = 1'b0;
    ptr_d            = ptr_q;
    if (gnt0_s) begin
      bus.o_mem_addr  = bus.i_req0_addr;
      bus.o_mem_wdata = bus.i_req0_wdata;
      bus.o_mem_be    = bus.i_req0_we ? bus.i_req0_be : 4'h0;
      bus.o_mem_wren  = bus.i_req0_we;
      push_vld_s      = ~bus.i_req0_we;
      ptr_d           = 1'b0;
    end else if (gnt1_s) begin
      bus.o_mem_addr  = bus.i_req1_addr;
      bus.o_mem_wdata = bus.i_req1_wdata;
      bus.o_mem_be    = bus.i_req1_we ? bus.i_req1_be : 4'h0;
      bus.o_mem_wren  = bus.i_req1_we;
      push_vld_s      = ~bus.i_req1_we;
      ptr_d           = 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
    tag_vld_d     = tag_vld_q << 1'b1;
    tag_port_d    = tag_port_q << 1'b1;
    tag_vld_d[0]  = push_vld_s;
    tag_port_d[0] = gnt1_s;
  end

  // Pointer and tag pipeline; reset drops any in-flight read tags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q      <= 1'b1;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
    end
  end

  // Response steering: RAM data is passed only to the port named by the oldest tag
  always_comb begin
    out_vld_s        = tag_vld_q[MEM_LAT-1] & ~i_rst;
    bus.o_rsp0_valid = out_vld_s & ~tag_port_q[MEM_LAT-1];
    bus.o_rsp1_valid = out_vld_s &  tag_port_q[MEM_LAT-1];
    bus.o_rsp0_rdata = bus.o_rsp0_valid ? bus.i_mem_rdata : 32'h0000_0000;
    bus.o_rsp1_rdata = bus.o_rsp1_valid ? bus.i_mem_rdata : 32'h0000_0000;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives identical traffic into a MEM_LAT=1 and a MEM_LAT=2 arbiter, each with its own RAM,
// and compares both against a cycle-level reference of the arbitration and memory contents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8)) busa ();
  dmem_arbiter_if #(.ADDR_W(8)) busb ();

  dmem_arbiter #(.ADDR_W(8), .MEM_LAT(1)) dut_a (.i_clk(clk), .i_rst(rst), .bus(busa));
  dmem_arbiter #(.ADDR_W(8), .MEM_LAT(2)) dut_b (.i_clk(clk), .i_rst(rst), .bus(busb));

  logic        v  [2];
  logic        we [2];
  logic [7:0]  ad [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];

  assign busa.i_req0_valid = v[0];  assign busb.i_req0_valid = v[0];
  assign busa.i_req0_we    = we[0]; assign busb.i_req0_we    = we[0];
  assign busa.i_req0_addr  = ad[0]; assign busb.i_req0_addr  = ad[0];
  assign busa.i_req0_wdata = wd[0]; assign busb.i_req0_wdata = wd[0];
  assign busa.i_req0_be    = be[0]; assign busb.i_req0_be    = be[0];
  assign busa.i_req1_valid = v[1];  assign busb.i_req1_valid = v[1];
  assign busa.i_req1_we    = we[1]; assign busb.i_req1_we    = we[1];
  assign busa.i_req1_addr  = ad[1]; assign busb.i_req1_addr  = ad[1];
  assign busa.i_req1_wdata = wd[1]; assign busb.i_req1_wdata = wd[1];
  assign busa.i_req1_be    = be[1]; assign busb.i_req1_be    = be[1];

  // RAM models: synchronous read, byte-masked write
  logic [31:0] rama [256];
  logic [31:0] ramb [256];
  logic [31:0] rda1, rdb1, rdb2;
  assign busa.i_mem_rdata = rda1;
  assign busb.i_mem_rdata = rdb2;

  always @(posedge clk) begin
    rda1 <= rama[busa.o_mem_addr];
    rdb1 <= ramb[busb.o_mem_addr];
    rdb2 <= rdb1;
    for (int b = 0; b < 4; b++) begin
      if (busa.o_mem_wren && busa.o_mem_be[b]) rama[busa.o_mem_addr][8*b +: 8] <= busa.o_mem_wdata[8*b +: 8];
      if (busb.o_mem_wren && busb.o_mem_be[b]) ramb[busb.o_mem_addr][8*b +: 8] <= busb.o_mem_wdata[8*b +: 8];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] refm [256];
  bit          pv [2][4096];
  bit          pp [2][4096];
  logic [31:0] pd [2][4096];
  int          last_m = 1;
  int          cyc    = 0;
  bit          gm [2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      rama[i] = 32'h0; ramb[i] = 32'h0; refm[i] = 32'h0;
    end
  end

  // Per-cycle reference: expected grant, RAM drive and responses, checked mid-cycle
  always @(negedge clk) begin
    int g;
    logic [31:0] e_addr, e_wd, e_be, e_wren;
    g = -1;
    if (rst) begin
      last_m = 1;
      for (int c = cyc; c < cyc + 3 && c < 4096; c++) begin
        pv[0][c] = 1'b0; pv[1][c] = 1'b0;
      end
    end else if (v[0] && v[1]) g = (last_m == 0) ? 1 : 0;
    else if (v[0]) g = 0;
    else if (v[1]) g = 1;

    check_eq("A.ready0", busa.o_req0_ready, g == 0);
    check_eq("A.ready1", busa.o_req1_ready, g == 1);
    check_eq("B.ready0", busb.o_req0_ready, g == 0);
    check_eq("B.ready1", busb.o_req1_ready, g == 1);

    e_addr = 0; e_wd = 0; e_be = 0; e_wren = 0;
    if (g >= 0) begin
      e_addr = ad[g]; e_wd = wd[g];
      e_be   = we[g] ? be[g] : 4'h0;
      e_wren = we[g];
    end
    check_eq("A.mem_addr",  busa.o_mem_addr,  e_addr);
    check_eq("A.mem_wdata", busa.o_mem_wdata, e_wd);
    check_eq("A.mem_be",    busa.o_mem_be,    e_be);
    check_eq("A.mem_wren",  busa.o_mem_wren,  e_wren);
    check_eq("B.mem_wren",  busb.o_mem_wren,  e_wren);

    check_eq("A.rsp0_valid", busa.o_rsp0_valid, pv[0][cyc] && !pp[0][cyc]);
    check_eq("A.rsp1_valid", busa.o_rsp1_valid, pv[0][cyc] &&  pp[0][cyc]);
    check_eq("A.rsp0_rdata", busa.o_rsp0_rdata, (pv[0][cyc] && !pp[0][cyc]) ? pd[0][cyc] : 32'h0);
    check_eq("A.rsp1_rdata", busa.o_rsp1_rdata, (pv[0][cyc] &&  pp[0][cyc]) ? pd[0][cyc] : 32'h0);
    check_eq("B.rsp0_valid", busb.o_rsp0_valid, pv[1][cyc] && !pp[1][cyc]);
    check_eq("B.rsp1_valid", busb.o_rsp1_valid, pv[1][cyc] &&  pp[1][cyc]);
    check_eq("B.rsp0_rdata", busb.o_rsp0_rdata, (pv[1][cyc] && !pp[1][cyc]) ? pd[1][cyc] : 32'h0);
    check_eq("B.rsp1_rdata", busb.o_rsp1_rdata, (pv[1][cyc] &&  pp[1][cyc]) ? pd[1][cyc] : 32'h0);

    gm[0] = (g == 0);
    gm[1] = (g == 1);
    if (g >= 0) begin
      last_m = g;
      if (we[g]) begin
        for (int b = 0; b < 4; b++)
          if (be[g][b]) refm[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
      end else begin
        for (int l = 0; l < 2; l++) begin
          pv[l][cyc+1+l] = 1'b1;
          pp[l][cyc+1+l] = (g == 1);
          pd[l][cyc+1+l] = refm[ad[g]];
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) if (gm[p]) v[p] = 1'b0;
  endtask

  task automatic set_req(input int p, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    v[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d; be[p] = b;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (v[0] || v[1]); i++) tick();
    check_eq("drain_timeout", {31'b0, v[0] | v[1]}, 32'h0);
  endtask

  initial begin
    set_req(0, 1'b0, 8'h01, 32'h0, 4'h0);
    set_req(1, 1'b0, 8'h02, 32'h0, 4'h0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    drain();

    // Lone requester: write then read back to back
    set_req(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
    tick();
    set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
    drain();
    repeat (3) tick();

    // Preload and continuous contention
    set_req(0, 1'b1, 8'h01, 32'h11, 4'hF);
    set_req(1, 1'b1, 8'h02, 32'h22, 4'hF);
    drain();
    set_req(0, 1'b0, 8'h01, 32'h0, 4'h0);
    set_req(1, 1'b0, 8'h02, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) begin v[0] = 1'b1; v[1] = 1'b1; end
    end
    drain();
    repeat (3) tick();

    // Partial byte-enable write from port 1, read back on port 0
    set_req(1, 1'b1, 8'h20, 32'h0, 4'hF);
    drain();
    set_req(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0011);
    drain();
    set_req(0, 1'b0, 8'h20, 32'h0, 4'h0);
    drain();
    repeat (3) tick();

    // Cross-port read after write on the very next cycle
    set_req(1, 1'b1, 8'h30, 32'h5, 4'hF);
    tick();
    set_req(0, 1'b0, 8'h30, 32'h0, 4'h0);
    drain();
    repeat (3) tick();

    // Reset right after a read is accepted
    set_req(0, 1'b0, 8'h10, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++)
        if (!v[p] && $urandom_range(1, 0) == 1)
          set_req(p, 1'($urandom_range(1, 0)), 8'($urandom_range(15, 0)),
                  32'($urandom), 4'($urandom_range(15, 0)));
      rst = ($urandom_range(63, 0) == 0);
      tick();
    end
    rst = 1'b0;
    drain();
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port data memory (256 x 32, synchronous read).
- Port 0 is the core LSU load/store path; port 1 is the debug/program-loader path.
- Grants at most one memory access per cycle using round-robin priority, drives the RAM port, and routes read data back to the issuing port after the fixed RAM read latency.

Parameters:
ADDR_W, 8, word-address width driven to the RAM.
MEM_LAT, 1, RAM read latency in cycles; legal values 1 or 2.

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous reset, active-high.
i_req0_valid  in  1  port 0 request valid.
i_req0_we  in  1  port 0 write (1) / read (0).
i_req0_addr  in  ADDR_W  port 0 word address.
i_req0_wdata  in  32  port 0 write data, already lane-aligned.
i_req0_be  in  4  port 0 byte enables (writes only).
o_req0_ready  out  1  port 0 request accepted this cycle.
o_rsp0_valid  out  1  port 0 read data valid.
o_rsp0_rdata  out  32  port 0 read data.
i_req1_valid, i_req1_we, i_req1_addr, i_req1_wdata, i_req1_be, o_req1_ready, o_rsp1_valid, o_rsp1_rdata: same as port 0, for port 1.
o_mem_addr  out  ADDR_W  RAM address.
o_mem_wdata  out  32  RAM write data.
o_mem_be  out  4  RAM byte enables.
o_mem_wren  out  1  RAM write enable.
i_mem_rdata  in  32  RAM read data, MEM_LAT cycles after address.

Behaviour:
- Clocking: one clock, i_clk. All state updates on the rising edge. Reset is synchronous, active-high, on i_rst.
- Reset values (any cycle with i_rst=1):
  - o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_mem_wren = 0.
  - o_mem_addr, o_mem_wdata, o_mem_be = 0.
  - o_rsp*_rdata = 0.
  - last-grant pointer = 1, so port 0 wins the first contention after reset.
  - Response tag pipeline cleared.
- Handshake: a request transfers when valid & ready in the same cycle.
  - Ready is combinational from the valids and the pointer.
  - A requester must hold valid and payload stable until ready.
  - Ready never asserts without valid.
- Arbitration, per cycle:
  - Only one valid: that port is granted.
  - Both valid: grant the port not equal to the last-grant pointer.
  - No valid: no grant; pointer holds.
  - On any grant, pointer <= granted port.
  - Result: strict alternation under continuous contention, and full throughput (one access per cycle) for a lone requester.
- Memory drive, combinational from the granted port:
  - o_mem_addr and o_mem_wdata come from the granted port.
  - o_mem_be = granted port be if we, else 0.
  - o_mem_wren = grant & we.
  - With no grant: o_mem_wren=0, o_mem_be=0, addr/wdata=0.
- Read tracking:
  - Each granted read pushes tag {valid=1, port} into a MEM_LAT-deep shift pipeline. Writes and idle cycles push valid=0.
  - At the pipeline output, o_rspN_valid=1 for exactly one cycle for the tagged port, with o_rspN_rdata = i_mem_rdata.
  - The non-tagged port has rsp_valid=0 and rdata=0.
  - Responses cannot be back-pressured. Read latency is exactly MEM_LAT cycles from the accept edge.
- Ordering and hazards:
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later, from either port.
  - A read and a write in the same cycle are impossible (single grant).
- Reset mid-operation: in-flight read tags are discarded and no response is produced for them. Requests presented during reset are not accepted.
- Pipelines: no combinational path from i_mem_rdata to any ready.

Test Plan:
- Reset: hold i_rst=1 for 3 cycles with both valids=1 -> both readies=0, o_mem_wren=0, no rsp_valid. Release -> first cycle grants port 0.
- Lone requester: port 0 writes 0xDEADBEEF, be=4'hF, to addr 8'h10, then reads 8'h10 back to back -> ready=1 both cycles; o_rsp0_valid exactly 1 cycle after the read accept, with rdata 0xDEADBEEF; o_rsp1_valid stays 0.
- Contention: both ports issue continuous reads (port 0 addr 8'h01, port 1 addr 8'h02, preloaded 0x11, 0x22) for 6 cycles -> grants alternate 0,1,0,1,0,1; responses alternate rsp0=0x11 / rsp1=0x22, each MEM_LAT after its grant.
- Byte enables: port 1 writes 0xAABBCCDD, be=4'b0011, over 0x00000000 at 8'h20; port 0 reads 8'h20 -> rdata 0x0000CCDD.
- Cross-port RAW: port 1 writes 0x5 to 8'h30 in cycle N; port 0 reads 8'h30 in cycle N+1 -> rsp0 returns 0x5.
- Reset mid-read: port 0 read accepted, i_rst=1 on the next edge (MEM_LAT=2) -> no o_rsp0_valid ever produced for that read. Repeat the directed cases with MEM_LAT=2 -> all latencies shift to 2.
